phy_rx_word_assembler: RTL
==========================

Name: phy_rx_word_assembler

Overview:
Receive-side counterpart of the transmit 32-bit register stage. It takes the received byte stream, achieves word alignment on COM characters, and packs four data bytes into a registered 32-bit word with a one-cycle valid. It sits after the receive byte path and delivers words to the receive-side consumers at the 32-bit interface.

Parameters:
COM_CHAR, 8'hBC, alignment/idle character.
LOCK_COUNT, 4, consecutive valid COM bytes required to lock (range 1..15).

Ports:
clk_4f  input  1  byte-rate clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
valid_in  input  1  data_in carries a received byte this cycle.
data_in  input  8  received byte.
valid_out  output  1  one-cycle pulse: data_out holds a complete word.
data_out  output  32  assembled word; first received byte in [31:24], last in [7:0].
active  output  1  high while in LOCKED.
align_err  output  1  one-cycle pulse on a misplaced COM while locked.

Behaviour:
- Reset: synchronous and active-high. On a clk_4f edge with reset=1, all state is cleared: state=SEARCH, com_cnt=0, byte_idx=0, partial word=0, valid_out=0, data_out=32'h0, active=0, align_err=0. Reset overrides every other input, including mid-word, and the partial word is discarded.
- A cycle with valid_in=0 is a stall. No state, counter, index or partial word changes, and valid_out and align_err are 0 in that cycle.
- SEARCH state:
  - Valid byte == COM_CHAR: com_cnt increments. When com_cnt reaches LOCK_COUNT, go to LOCKED, with byte_idx=0 and com_cnt=0.
  - Valid byte != COM_CHAR: com_cnt=0 and the byte is discarded.
  - Non-consecutive COMs separated by stall cycles still count as consecutive, because stalls are ignored.
- LOCKED state, active=1 (registered; rises the cycle after the locking COM):
  - Valid COM with byte_idx==0: treated as idle filler and dropped; stays LOCKED.
  - Valid COM with byte_idx!=0: partial word discarded. align_err=1 for one cycle, byte_idx=0, state goes to SEARCH with com_cnt=1 (this COM counts toward re-lock). valid_out does not pulse.
  - Valid non-COM byte: stored into lane byte_idx, where lane 0 is [31:24]. byte_idx increments modulo 4.
  - On the 4th byte (byte_idx 3 to 0), data_out is loaded with the complete word and valid_out=1 on the following cycle. Latency is one clk_4f cycle from the edge sampling the last byte to the valid_out pulse.
- data_out holds its last value between pulses and changes only when valid_out pulses or on reset.
- Back-to-back words with no stalls yield a valid_out pulse every 4 cycles. There is no back-pressure; the consumer must accept every pulse.
- Data bytes equal to COM_CHAR cannot be carried; the encoding upstream guarantees this.

Test Plan:
1. reset=1 for 2 cycles with valid_in=1 and data_in=8'hBC → all outputs 0, no lock. Release reset, send 4×BC → active=1 one cycle after the 4th BC.
2. Locked, then send 11,22,33,44 with no stalls → exactly one valid_out pulse one cycle after 44, data_out=32'h11223344.
3. Locked, then send AA, stall 3 cycles, BB, BC(idle between words is not allowed here), … Specifically: AA, BB, then BC → align_err pulse, active=0, no valid_out. Then 3 more BC → re-lock (total 4 including the error COM).
4. Search with BC,BC,55,BC,BC,BC → no lock. Adding one more BC → lock, because the count restarted at the 55.
5. Locked, send AA,BB,CC,DD,BC,BC,01,02,03,04 → pulses with data_out=32'hAABBCCDD then 32'h01020304; BC idles dropped; align_err stays 0.
6. Assert reset after 2 bytes of a word, release, re-lock, send 4 bytes → the first pulse contains only the new bytes, with no residue from the old partial word.

Source files
------------

// File: rtl/phy_rx_word_assembler.sv
// Receive word assembler: finds word alignment on COM characters and packs
// four data bytes (first byte in [31:24]) into a registered 32-bit word.
module phy_rx_word_assembler #(
    parameter logic [7:0] COM_CHAR   = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [7:0]  data_in,
    output logic        valid_out,
    output logic [31:0] data_out,
    output logic        active,
    output logic        align_err
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  com_cnt_q, com_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] part_q, part_d;
    logic [31:0] data_out_q, data_out_d;
    logic        valid_out_q, valid_out_d;
    logic        active_q, active_d;
    logic        align_err_q, align_err_d;
    logic [3:0]  com_cnt_inc;

    assign com_cnt_inc = com_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        com_cnt_d   = com_cnt_q;
        byte_idx_d  = byte_idx_q;
        part_d      = part_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        align_err_d = 1'b0;

        // Stall cycles (valid_in=0) leave every piece of state untouched.
        if (valid_in) begin
            case (state_q)
                SEARCH: begin
                    if (data_in == COM_CHAR) begin
                        // >= so a re-lock seeded with count 1 still works when LOCK_COUNT is 1.
                        if (com_cnt_inc >= LOCK_CNT) begin
                            state_d    = LOCKED;
                            com_cnt_d  = 4'd0;
                            byte_idx_d = 2'd0;
                        end else begin
                            com_cnt_d = com_cnt_inc;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (data_in == COM_CHAR) begin
                        if (byte_idx_q != 2'd0) begin
                            align_err_d = 1'b1;
                            state_d     = SEARCH;
                            com_cnt_d   = 4'd1;
                            byte_idx_d  = 2'd0;
                            part_d      = 32'h0;
                        end
                    end else begin
                        case (byte_idx_q)
                            2'd0: part_d[31:24] = data_in;
                            2'd1: part_d[23:16] = data_in;
                            2'd2: part_d[15:8]  = data_in;
                            default: begin
                                data_out_d  = {part_q[31:8], data_in};
                                valid_out_d = 1'b1;
                                part_d      = 32'h0;
                            end
                        endcase
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        active_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q     <= SEARCH;
            com_cnt_q   <= 4'd0;
            byte_idx_q  <= 2'd0;
            part_q      <= 32'h0;
            data_out_q  <= 32'h0;
            valid_out_q <= 1'b0;
            active_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            com_cnt_q   <= com_cnt_d;
            byte_idx_q  <= byte_idx_d;
            part_q      <= part_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            active_q    <= active_d;
            align_err_q <= align_err_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign active    = active_q;
    assign align_err = align_err_q;

endmodule
